ascii_hid_keystroke: RTL and testbench

// - Streaming ASCII-to-USB-HID keystroke generator; successor to the combinational ASCII->HID lookup.
// - Buffers incoming 7-bit ASCII characters in a small FIFO and emits a press/release pair of
//   8-byte boot-keyboard reports per character.
// - Enforces key hold and inter-key gap timing; drops and counts unmappable characters.
// - Sits between the text source (UART/ROM string reader) and the USB HID endpoint logic.

---
 rtl/usb_hid_pkg.sv | 37 +++
 rtl/ascii_hid_lut.sv | 67 ++++++
 rtl/ascii_hid_keystroke.sv | 185 ++++++++++++++++++
 tb/tb_ascii_hid_keystroke.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_hid_pkg.sv
// Shared types and constants for the ASCII-to-HID keystroke generator.
package usb_hid_pkg;

  // 8-byte boot-keyboard report; modifier occupies bits [7:0], key1 bits [23:16].
  typedef struct packed {
    logic [7:0] key6;
    logic [7:0] key5;
    logic [7:0] key4;
    logic [7:0] key3;
    logic [7:0] key2;
    logic [7:0] key1;
    logic [7:0] reserved;
    logic [7:0] modifier;
  } hid_report_t;

  localparam logic [7:0]  HID_MOD_LSHIFT = 8'h02;
  localparam int unsigned LUT_SHIFT_BIT  = 7;
  localparam logic [7:0]  LUT_UNMAPPED   = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StPress,
    StHold,
    StRelease,
    StGap
  } ks_state_e;

  // Build the press report for a mapped LUT entry.
  function automatic hid_report_t make_press(input logic [7:0] entry);
    hid_report_t r;
    r          = '0;
    r.modifier = entry[LUT_SHIFT_BIT] ? HID_MOD_LSHIFT : 8'h00;
    r.key1     = {1'b0, entry[6:0]};
    return r;
  endfunction

endpackage

// File: rtl/ascii_hid_lut.sv
// Combinational US-layout ASCII to HID usage table.
// Entry format: bit7 = shift required, [6:0] = HID usage; 8'h00 = unmapped.
module ascii_hid_lut
  import usb_hid_pkg::*;
(
  input  logic [6:0] ascii_i,
  output logic [7:0] entry_o
);

  // Letter and digit ranges are arithmetic; everything else is an explicit entry.
  always_comb begin
    entry_o = LUT_UNMAPPED;
    if (ascii_i >= 7'h61 && ascii_i <= 7'h7a) begin
      entry_o = {1'b0, ascii_i - 7'h61 + 7'h04};
    end else if (ascii_i >= 7'h41 && ascii_i <= 7'h5a) begin
      entry_o = {1'b1, ascii_i - 7'h41 + 7'h04};
    end else if (ascii_i >= 7'h31 && ascii_i <= 7'h39) begin
      entry_o = {1'b0, ascii_i - 7'h31 + 7'h1e};
    end else begin
      case (ascii_i)
        7'h08:   entry_o = 8'h2a;  // backspace
        7'h11:   entry_o = 8'h5c;  // DC1 -> keypad left
        7'h12:   entry_o = 8'h5a;  // DC2 -> keypad down
        7'h13:   entry_o = 8'h60;  // DC3 -> keypad up
        7'h14:   entry_o = 8'h5e;  // DC4 -> keypad right
        7'h1b:   entry_o = 8'h29;  // escape
        7'h20:   entry_o = 8'h2c;
        7'h21:   entry_o = 8'h9e;
        7'h22:   entry_o = 8'hb4;
        7'h23:   entry_o = 8'ha0;
        7'h24:   entry_o = 8'ha1;
        7'h25:   entry_o = 8'ha2;
        7'h26:   entry_o = 8'ha4;
        7'h27:   entry_o = 8'h34;
        7'h28:   entry_o = 8'ha6;
        7'h29:   entry_o = 8'ha7;
        7'h2a:   entry_o = 8'ha5;
        7'h2b:   entry_o = 8'hae;
        7'h2c:   entry_o = 8'h36;
        7'h2d:   entry_o = 8'h2d;
        7'h2e:   entry_o = 8'h37;
        7'h2f:   entry_o = 8'h38;
        7'h30:   entry_o = 8'h27;
        7'h3a:   entry_o = 8'hb3;
        7'h3b:   entry_o = 8'h33;
        7'h3c:   entry_o = 8'hb6;
        7'h3d:   entry_o = 8'h2e;
        7'h3e:   entry_o = 8'hb7;
        7'h3f:   entry_o = 8'hb8;
        7'h40:   entry_o = 8'h9f;
        7'h5b:   entry_o = 8'h2f;
        7'h5c:   entry_o = 8'h31;
        7'h5d:   entry_o = 8'h30;
        7'h5e:   entry_o = 8'ha3;
        7'h5f:   entry_o = 8'had;
        7'h60:   entry_o = 8'h35;
        7'h7b:   entry_o = 8'haf;
        7'h7c:   entry_o = 8'hb1;
        7'h7d:   entry_o = 8'hb0;
        7'h7e:   entry_o = 8'hb5;
        7'h7f:   entry_o = 8'h4c;  // DEL -> delete forward
        default: entry_o = LUT_UNMAPPED;
      endcase
    end
  end

endmodule

// File: rtl/ascii_hid_keystroke.sv
// Streaming ASCII-to-HID keystroke generator: FIFO, press/hold/release/gap sequencer,
// unmapped-character drop counter.
module ascii_hid_keystroke
  import usb_hid_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       char_data,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic             flush,
  output logic [63:0]      report_data,
  output logic             report_valid,
  input  logic             report_ready,
  output logic             busy,
  output logic             err_unmapped,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned TmrMax  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TmrW    = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] HoldLoad = TmrW'(HOLD_CYCLES - 1);
  localparam logic [TmrW-1:0] GapLoad  = (GAP_CYCLES == 0) ? '0 : TmrW'(GAP_CYCLES - 1);

  logic [6:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            fifo_full, fifo_empty, push, pop;

  ks_state_e        state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic             valid_q, valid_d;
  hid_report_t      report_q, report_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [7:0]       lut_entry;
  logic             accept;

  assign fifo_full  = (count_q == (PtrW + 1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  // A push during flush is discarded; the FIFO only pops while idle.
  assign push   = char_valid && !fifo_full && !flush;
  assign pop    = (state_q == StIdle) && !fifo_empty && !flush;
  assign accept = valid_q && report_ready;

  ascii_hid_lut u_lut (
    .ascii_i (mem_q[rd_ptr_q]),
    .entry_o (lut_entry)
  );

  // FIFO storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= char_data;
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  // Keystroke sequencer next-state; all outputs are registered.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    valid_d  = valid_q;
    report_d = report_q;
    err_d    = 1'b0;
    drop_d   = drop_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          if (lut_entry == LUT_UNMAPPED) begin
            err_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
          end else begin
            state_d  = StPress;
            valid_d  = 1'b1;
            report_d = make_press(lut_entry);
          end
        end
      end
      StPress: begin
        if (flush) begin
          // A press already seen by the host must still be released.
          report_d = '0;
          if (accept) begin
            state_d = StRelease;
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
          end
        end else if (accept) begin
          state_d  = StHold;
          valid_d  = 1'b0;
          report_d = '0;
          tmr_d    = HoldLoad;
        end
      end
      StHold: begin
        if (flush || tmr_q == '0) begin
          state_d  = StRelease;
          valid_d  = 1'b1;
          report_d = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StRelease: begin
        if (accept) begin
          valid_d = 1'b0;
          if (flush || GAP_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            tmr_d   = GapLoad;
          end
        end
      end
      StGap: begin
        if (flush || tmr_q == '0) begin
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      tmr_q    <= '0;
      valid_q  <= 1'b0;
      report_q <= '0;
      err_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      valid_q  <= valid_d;
      report_q <= report_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
    end
  end

  assign char_ready   = !fifo_full;
  assign report_data  = report_q;
  assign report_valid = valid_q;
  assign busy         = !fifo_empty || (state_q != StIdle);
  assign err_unmapped = err_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_ascii_hid_keystroke.sv
// Directed bench for ascii_hid_keystroke with a queue-based report model.
module tb_ascii_hid_keystroke;

  localparam int Depth = 16;
  localparam int Hold  = 4;
  localparam int Gap   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        flush;
  logic [63:0] report_data;
  logic        report_valid;
  logic        report_ready;
  logic        busy;
  logic        err_unmapped;
  logic [7:0]  drop_count;

  ascii_hid_keystroke #(
    .DEPTH       (Depth),
    .HOLD_CYCLES (Hold),
    .GAP_CYCLES  (Gap),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_data    (char_data),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .flush        (flush),
    .report_data  (report_data),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .busy         (busy),
    .err_unmapped (err_unmapped),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          exp_drops = 0;
  int          err_pulses = 0;
  int          idle_cyc = 0;
  logic [63:0] exp_q[$];
  logic [63:0] hs_data[$];
  int          hs_cyc[$];
  logic        stall_prev = 1'b0;
  logic        flush_prev = 1'b0;
  logic [63:0] data_prev = '0;
  logic        acc_last = 1'b0;

  // US keyboard layout: punctuation rows given as ASCII codes.
  function automatic logic [7:0] model_entry(input logic [6:0] c);
    string       dig_s;
    int          pun   [11];
    int          pun_s [11];
    logic [7:0]  pun_key [11];
    logic [7:0]  r;
    int          ci;
    dig_s   = "!@#$%^&*()";
    pun     = '{45, 61, 91, 93, 92, 59, 39, 96, 44, 46, 47};
    pun_s   = '{95, 43, 123, 125, 124, 58, 34, 126, 60, 62, 63};
    pun_key = '{8'h2d, 8'h2e, 8'h2f, 8'h30, 8'h31, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    ci = int'(c);
    r  = 8'h00;
    if (ci >= 97 && ci <= 122)      r = {1'b0, 7'(ci - 97 + 4)};
    else if (ci >= 65 && ci <= 90)  r = {1'b1, 7'(ci - 65 + 4)};
    else if (ci >= 49 && ci <= 57)  r = {1'b0, 7'(ci - 49 + 30)};
    else if (ci == 48)              r = 8'h27;
    else if (ci == 32)              r = 8'h2c;
    else if (ci == 8)               r = 8'h2a;
    else if (ci == 17)              r = 8'h5c;
    else if (ci == 18)              r = 8'h5a;
    else if (ci == 19)              r = 8'h60;
    else if (ci == 20)              r = 8'h5e;
    else if (ci == 27)              r = 8'h29;
    else if (ci == 127)             r = 8'h4c;
    for (int i = 0; i < 10; i++) begin
      if (r == 8'h00 && ci == int'(dig_s[i])) r = {1'b1, 7'(30 + i)};
    end
    for (int i = 0; i < 11; i++) begin
      if (r == 8'h00 && ci == pun[i])   r = pun_key[i];
      if (r == 8'h00 && ci == pun_s[i]) r = pun_key[i] | 8'h80;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle observer: feeds the model from accepted chars and checks every handshake.
  task automatic monitor();
    logic [7:0] e;
    cyc++;
    acc_last = 1'b0;
    if (char_valid && char_ready && !flush) begin
      acc_last = 1'b1;
      e = model_entry(char_data);
      if (e == 8'h00) begin
        exp_drops++;
      end else begin
        exp_q.push_back({40'h0, 1'b0, e[6:0], 8'h00, (e[7] ? 8'h02 : 8'h00)});
        exp_q.push_back(64'h0);
      end
    end
    if (err_unmapped) err_pulses++;
    if (stall_prev && !flush_prev) begin
      check("stall_valid", {63'h0, report_valid}, 64'h1);
      if (report_valid) check("stall_data", report_data, data_prev);
    end
    if (report_valid && report_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_report: got %h, required no report (cycle %0d)",
                 report_data, cyc);
      end else begin
        check("report", report_data, exp_q.pop_front());
      end
      hs_data.push_back(report_data);
      hs_cyc.push_back(cyc);
    end
    stall_prev = report_valid && !report_ready;
    flush_prev = flush;
    data_prev  = report_data;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      monitor();
      if (!busy && exp_q.size() == 0) begin
        done     = 1'b1;
        idle_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy=%0b, pending=%0d, required idle within %0d cycles",
               busy, exp_q.size(), budget);
    end
  endtask

  task automatic send(input logic [6:0] c);
    char_valid = 1'b1;
    char_data  = c;
    step();
    char_valid = 1'b0;
  endtask

  initial begin
    int    b;
    int    k;
    int    extra;
    int    budget;
    int    p0;
    string msg;
    rst_n        = 1'b1;
    char_data    = '0;
    char_valid   = 1'b0;
    flush        = 1'b0;
    report_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'h0, report_valid}, 64'h0);
    check("rst_data", report_data, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_ready", {63'h0, char_ready}, 64'h1);
    check("rst_drop", {56'h0, drop_count}, 64'h0);
    rst_n = 1'b1;
    step();

    // 'a': press, release HOLD later, busy drops after GAP
    b = hs_data.size();
    send(7'h61);
    wait_idle(60);
    check("a_press", hs_data[b], 64'h0000_0000_0004_0000);
    check("a_release", hs_data[b+1], 64'h0);
    check("a_hold", 64'(hs_cyc[b+1] - hs_cyc[b]), 64'(Hold + 1));
    check("a_gap_busy", 64'(idle_cyc - hs_cyc[b+1]), 64'(Gap + 1));

    // 'A' then '!': both shifted
    b = hs_data.size();
    send(7'h41);
    send(7'h21);
    wait_idle(80);
    check("A_press", hs_data[b], 64'h0000_0000_0004_0002);
    check("A_release", hs_data[b+1], 64'h0);
    check("bang_press", hs_data[b+2], 64'h0000_0000_001e_0002);
    check("bang_release", hs_data[b+3], 64'h0);

    // "oo": two distinct presses separated by at least the gap
    b = hs_data.size();
    send(7'h6f);
    send(7'h6f);
    wait_idle(80);
    check("oo_count", 64'(hs_data.size() - b), 64'd4);
    check("oo_press2", hs_data[b+2], 64'h0000_0000_0012_0000);
    check("oo_gap", {63'h0, (hs_cyc[b+2] - hs_cyc[b+1]) > Gap}, 64'h1);

    // 0x01, 0x00, 'b': two drops and one press
    b = hs_data.size();
    k = err_pulses;
    send(7'h01);
    send(7'h00);
    send(7'h62);
    wait_idle(60);
    check("unm_pulses", 64'(err_pulses - k), 64'd2);
    check("unm_drop", {56'h0, drop_count}, 64'd2);
    check("unm_drop_model", {56'h0, drop_count}, 64'(exp_drops));
    check("unm_count", 64'(hs_data.size() - b), 64'd2);
    check("unm_b_press", hs_data[b], 64'h0000_0000_0005_0000);

    // Stall: 17 chars accepted (one in PRESS), FIFO then full
    msg          = "Hello, World! 123";
    report_ready = 1'b0;
    k            = 0;
    budget       = 0;
    char_valid   = 1'b1;
    char_data    = 7'(msg[0]);
    while (k < 17 && budget < 40) begin
      step();
      budget++;
      if (acc_last) begin
        k++;
        if (k < 17) char_data = 7'(msg[k]);
      end
    end
    char_valid = 1'b0;
    check("stall_accepted", 64'(k), 64'(Depth + 1));
    check("stall_full", {63'h0, char_ready}, 64'h0);
    check("stall_press", report_data, 64'h0000_0000_000b_0002);
    extra      = 0;
    char_valid = 1'b1;
    char_data  = 7'h78;
    repeat (3) begin
      step();
      if (acc_last) extra++;
    end
    char_valid = 1'b0;
    check("stall_refused", 64'(extra), 64'd0);
    report_ready = 1'b1;
    wait_idle(600);

    // Flush in HOLD with 5 queued: only the release follows
    b            = hs_data.size();
    report_ready = 1'b0;
    msg          = "zqwert";
    for (int i = 0; i < 6; i++) send(7'(msg[i]));
    report_ready = 1'b1;
    budget       = 0;
    while (hs_data.size() == b && budget < 10) begin
      step();
      budget++;
    end
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    flush      = 1'b1;
    char_valid = 1'b1;
    char_data  = 7'h6b;
    step();
    flush      = 1'b0;
    char_valid = 1'b0;
    check("flush_rel_valid", {63'h0, report_valid}, 64'h1);
    check("flush_rel_data", report_data, 64'h0);
    wait_idle(40);
    check("flush_count", 64'(hs_data.size() - b), 64'd2);
    check("flush_ready", {63'h0, char_ready}, 64'h1);

    // Reset asserted mid-PRESS clears outputs at once; no release afterwards
    report_ready = 1'b0;
    send(7'h70);
    step();
    check("pre_rst_valid", {63'h0, report_valid}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {63'h0, report_valid}, 64'h0);
    check("arst_data", report_data, 64'h0);
    check("arst_busy", {63'h0, busy}, 64'h0);
    check("arst_drop", {56'h0, drop_count}, 64'h0);
    check("arst_ready", {63'h0, char_ready}, 64'h1);
    exp_q.delete();
    exp_drops  = 0;
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    report_ready = 1'b1;
    p0 = hs_data.size();
    repeat (6) step();
    check("post_rst_silent", 64'(hs_data.size() - p0), 64'd0);
    check("post_rst_idle", {63'h0, busy}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
